ultrasonic_scheduler: RTL and testbench

Sequences one shared sensor_driver across N_SENSORS ultrasonic sensors in round-robin sweeps. Each sweep selects one sensor at a time, fires a measurement, waits for completion or timeout, then holds a guard interval so echoes do not cross-talk. Per-sensor distances are latched and compared against a runtime threshold to produce an obstacle flag. It sits between refresher250ms (sweep start) and sensor_driver; the top level routes the trig/echo mux from `sel`.

---
 rtl/ultrasonic_scheduler.sv | 171 +++++++++++++++++
 tb/tb_ultrasonic_scheduler.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_scheduler.sv
// ultrasonic_scheduler: round-robin sweep sequencer for one shared sensor_driver.
// Fires each sensor in turn, waits for a result or timeout, then holds a guard
// interval before moving on. Latches per-sensor distance, near and timeout flags.
module ultrasonic_scheduler #(
    parameter int unsigned N_SENSORS      = 3,
    parameter int unsigned DIST_W         = 10,
    parameter int unsigned GUARD_CYCLES   = 3_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
    localparam int unsigned SEL_W         = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        start,
    input  logic [DIST_W-1:0]           threshold,
    output logic                        drv_measure,
    input  logic                        drv_done,
    input  logic [DIST_W-1:0]           drv_distance,
    output logic [SEL_W-1:0]            sel,
    output logic [N_SENSORS*DIST_W-1:0] dist_flat,
    output logic [N_SENSORS-1:0]        near,
    output logic [N_SENSORS-1:0]        timed_out,
    output logic                        obstacle,
    output logic                        busy,
    output logic                        sweep_done
);

    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [SEL_W-1:0] LAST_SEL     = SEL_W'(N_SENSORS - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    // GUARD is entered one cycle after the result lands, so counting to
    // GUARD_CYCLES inclusive places the next measure at done + 2 + GUARD_CYCLES.
    localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT,
        S_GUARD,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic                 pending;
    logic [DIST_W-1:0]    dist_q [N_SENSORS];
    logic [N_SENSORS-1:0] near_nxt;
    logic                 timeout_hit;
    logic                 guard_end;
    logic                 meas_ok;
    logic                 meas_to;

    // Measurement outcome qualifiers for the current cycle
    always_comb begin
        timeout_hit = (cnt == TIMEOUT_LAST);
        guard_end   = (cnt == GUARD_LAST);
        meas_ok     = (state == S_WAIT) && en && drv_done;
        meas_to     = (state == S_WAIT) && en && !drv_done && timeout_hit;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; dropping en aborts any active sweep
    always_comb begin
        state_nxt = state;
        if (state != S_IDLE && !en) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (en && (start || pending)) state_nxt = S_TRIG;
                S_TRIG:  state_nxt = S_WAIT;
                S_WAIT:  if (drv_done || timeout_hit) state_nxt = S_GUARD;
                S_GUARD: if (guard_end) state_nxt = (sel == LAST_SEL) ? S_DONE : S_TRIG;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the current state
    always_comb begin
        drv_measure = (state == S_TRIG);
        busy        = (state == S_TRIG) || (state == S_WAIT) || (state == S_GUARD);
        sweep_done  = (state == S_DONE);
    end

    // Cycle counter, sensor index and one-deep pending sweep request
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            sel     <= '0;
            pending <= 1'b0;
        end else begin
            if (state_nxt != state || (state != S_WAIT && state != S_GUARD)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if (state_nxt == S_IDLE || state_nxt == S_DONE) begin
                sel <= '0;
            end else if (state == S_GUARD && state_nxt == S_TRIG) begin
                sel <= sel + SEL_W'(1);
            end

            if (!en || state == S_IDLE) begin
                pending <= 1'b0;
            end else if (start) begin
                pending <= 1'b1;
            end
        end
    end

    // Near flags as they will be after this cycle's measurement outcome
    always_comb begin
        near_nxt = near;
        for (int unsigned i = 0; i < N_SENSORS; i++) begin
            if (sel == SEL_W'(i)) begin
                if (meas_ok) begin
                    near_nxt[i] = (drv_distance < threshold);
                end else if (meas_to) begin
                    near_nxt[i] = 1'b0;
                end
            end
        end
    end

    // Per-sensor result registers; obstacle tracks near in the same cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N_SENSORS; i++) begin
                dist_q[i] <= '0;
            end
            near      <= '0;
            timed_out <= '0;
            obstacle  <= 1'b0;
        end else begin
            near     <= near_nxt;
            obstacle <= |near_nxt;
            for (int unsigned i = 0; i < N_SENSORS; i++) begin
                if (sel == SEL_W'(i)) begin
                    if (meas_ok) begin
                        dist_q[i]    <= drv_distance;
                        timed_out[i] <= 1'b0;
                    end else if (meas_to) begin
                        dist_q[i]    <= '1;
                        timed_out[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Flatten latched distances onto the output bus
    always_comb begin
        dist_flat = '0;
        for (int unsigned i = 0; i < N_SENSORS; i++) begin
            dist_flat[i*DIST_W +: DIST_W] = dist_q[i];
        end
    end

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Self-checking bench for ultrasonic_scheduler with a transaction-level sweep model.
module tb_ultrasonic_scheduler;

    localparam int unsigned N  = 3;
    localparam int unsigned DW = 10;
    localparam int unsigned G  = 4;
    localparam int unsigned T  = 20;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            en = 1'b0;
    logic            start = 1'b0;
    logic [DW-1:0]   threshold = 10'd100;
    logic            drv_done = 1'b0;
    logic [DW-1:0]   drv_distance = '0;
    logic            drv_measure;
    logic [1:0]      sel;
    logic [N*DW-1:0] dist_flat;
    logic [N-1:0]    near;
    logic [N-1:0]    timed_out;
    logic            obstacle;
    logic            busy;
    logic            sweep_done;

    ultrasonic_scheduler #(
        .N_SENSORS(N),
        .DIST_W(DW),
        .GUARD_CYCLES(G),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .start(start),
        .threshold(threshold),
        .drv_measure(drv_measure),
        .drv_done(drv_done),
        .drv_distance(drv_distance),
        .sel(sel),
        .dist_flat(dist_flat),
        .near(near),
        .timed_out(timed_out),
        .obstacle(obstacle),
        .busy(busy),
        .sweep_done(sweep_done)
    );

    initial forever #5 clk = ~clk;

    // delay = cycles after drv_measure at which drv_done is driven; 0 = never
    typedef struct {
        int unsigned   delay;
        logic [DW-1:0] val;
    } resp_t;

    int unsigned   cyc = 0;
    resp_t         resp_q[$];
    resp_t         plan[6];
    int unsigned   meas_cyc[$];
    logic [1:0]    meas_sel[$];
    logic          meas_busy[$];
    int unsigned   done_cyc[$];
    logic          resp_armed = 1'b0;
    int unsigned   resp_at = 0;
    logic [DW-1:0] resp_val = '0;

    logic [DW-1:0] m_dist[N];
    logic [N-1:0]  m_near = '0;
    logic [N-1:0]  m_to = '0;
    int unsigned   exp_m[6];

    int tests_run = 0;
    int tests_failed = 0;

    // One clock: sample outputs after the edge, then play the driver for this cycle
    task automatic tick();
        resp_t r;
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
        drv_done = 1'b0;
        drv_distance = DW'($urandom);
        if (drv_measure) begin
            meas_cyc.push_back(cyc);
            meas_sel.push_back(sel);
            meas_busy.push_back(busy);
            resp_armed = 1'b0;
            if (resp_q.size() > 0) begin
                r = resp_q.pop_front();
                if (r.delay != 0) begin
                    resp_armed = 1'b1;
                    resp_at = cyc + r.delay;
                    resp_val = r.val;
                end
            end
        end
        if (resp_armed && cyc == resp_at) begin
            drv_done = 1'b1;
            drv_distance = resp_val;
            resp_armed = 1'b0;
        end
        if (sweep_done) done_cyc.push_back(cyc);
    endtask

    task automatic clear_records();
        meas_cyc.delete();
        meas_sel.delete();
        meas_busy.delete();
        done_cyc.delete();
        resp_q.delete();
        resp_armed = 1'b0;
    endtask

    // Sweep model: answer within T cycles is accepted, otherwise timeout at T;
    // next sensor fires 2+G cycles after completion. Returns sweep_done cycle.
    function automatic int unsigned model_sweep(input int unsigned first_m, input int unsigned base);
        int unsigned m = first_m;
        int unsigned c;
        for (int unsigned i = 0; i < N; i++) begin
            exp_m[base+i] = m;
            if (plan[base+i].delay >= 1 && plan[base+i].delay <= T) begin
                c = m + plan[base+i].delay;
                m_dist[i] = plan[base+i].val;
                m_to[i] = 1'b0;
                m_near[i] = (plan[base+i].val < threshold);
            end else begin
                c = m + T;
                m_dist[i] = '1;
                m_to[i] = 1'b1;
                m_near[i] = 1'b0;
            end
            m = c + 2 + G;
        end
        return m;
    endfunction

    function automatic logic [N*DW-1:0] exp_flat();
        logic [N*DW-1:0] f;
        for (int unsigned i = 0; i < N; i++) f[i*DW +: DW] = m_dist[i];
        return f;
    endfunction

    // Runs one sweep of plan[0..N-1] and checks timing and latched results
    task automatic run_sweep(input string name);
        int unsigned s;
        int unsigned exp_done;
        clear_records();
        for (int unsigned i = 0; i < N; i++) resp_q.push_back(plan[i]);
        s = cyc;
        start = 1'b1;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (done_cyc.size() > 0) break;
        end
        tick();
        tick();
        exp_done = model_sweep(s + 1, 0);

        tests_run++;
        if (meas_cyc.size() !== N) begin
            tests_failed++;
            $display("FAIL %s measure_count: got %0d, want %0d", name, meas_cyc.size(), N);
        end
        for (int unsigned i = 0; i < N && i < meas_cyc.size(); i++) begin
            tests_run++;
            if (meas_cyc[i] !== exp_m[i]) begin
                tests_failed++;
                $display("FAIL %s measure_cycle[%0d]: got %0d, want %0d", name, i, meas_cyc[i], exp_m[i]);
            end
            tests_run++;
            if (meas_sel[i] !== 2'(i) || meas_busy[i] !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s sel_busy_at_measure[%0d]: got sel=%0d busy=%b, want sel=%0d busy=1",
                         name, i, meas_sel[i], meas_busy[i], i);
            end
        end
        tests_run++;
        if (done_cyc.size() !== 1) begin
            tests_failed++;
            $display("FAIL %s sweep_done_count: got %0d, want 1", name, done_cyc.size());
        end else begin
            tests_run++;
            if (done_cyc[0] !== exp_done) begin
                tests_failed++;
                $display("FAIL %s sweep_done_cycle: got %0d, want %0d", name, done_cyc[0], exp_done);
            end
        end
        tests_run++;
        if (dist_flat !== exp_flat()) begin
            tests_failed++;
            $display("FAIL %s dist_flat: got %h, want %h", name, dist_flat, exp_flat());
        end
        tests_run++;
        if (near !== m_near || obstacle !== (|m_near)) begin
            tests_failed++;
            $display("FAIL %s near_obstacle: got %b/%b, want %b/%b", name, near, obstacle, m_near, |m_near);
        end
        tests_run++;
        if (timed_out !== m_to) begin
            tests_failed++;
            $display("FAIL %s timed_out: got %b, want %b", name, timed_out, m_to);
        end
        tests_run++;
        if (busy !== 1'b0 || sel !== 2'd0) begin
            tests_failed++;
            $display("FAIL %s idle_after: got busy=%b sel=%0d, want 0/0", name, busy, sel);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en = 1'b0;
        for (int unsigned i = 0; i < N; i++) m_dist[i] = '0;
        m_near = '0;
        m_to = '0;
        repeat (3) tick();
        tests_run++;
        if ({drv_measure, sel, dist_flat, near, timed_out, obstacle, busy, sweep_done} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got meas=%b sel=%0d dist=%h near=%b to=%b obs=%b busy=%b done=%b, want all 0",
                     drv_measure, sel, dist_flat, near, timed_out, obstacle, busy, sweep_done);
        end
        rst = 1'b1;
        clear_records();
        start = 1'b1;
        repeat (10) tick();
        tests_run++;
        if (meas_cyc.size() !== 0) begin
            tests_failed++;
            $display("FAIL start_while_disabled: got %0d measures, want 0", meas_cyc.size());
        end
        en = 1'b1;
        repeat (100) tick();
        tests_run++;
        if (meas_cyc.size() !== 0 || done_cyc.size() !== 0) begin
            tests_failed++;
            $display("FAIL idle_no_measure: got %0d measures %0d dones, want 0/0", meas_cyc.size(), done_cyc.size());
        end
        tests_run++;
        if ({drv_measure, sel, dist_flat, near, timed_out, obstacle, busy, sweep_done} !== '0) begin
            tests_failed++;
            $display("FAIL idle_outputs: got busy=%b sel=%0d dist=%h, want all 0", busy, sel, dist_flat);
        end
    endtask

    task automatic test_sweep();
        threshold = 10'd100;
        plan[0] = '{5, 10'd250};
        plan[1] = '{5, 10'd80};
        plan[2] = '{5, 10'd300};
        run_sweep("basic_sweep");
    endtask

    task automatic test_timeout();
        threshold = 10'd100;
        plan[0] = '{6, 10'd120};
        plan[1] = '{0, 10'd0};
        plan[2] = '{7, 10'd40};
        run_sweep("timeout");
    endtask

    task automatic test_exact_timeout();
        threshold = 10'd100;
        plan[0] = '{T, 10'd50};
        plan[1] = '{3, 10'd500};
        plan[2] = '{T + 1, 10'd20};
        run_sweep("exact_timeout");
    endtask

    task automatic test_random();
        int unsigned kind;
        for (int k = 0; k < 8; k++) begin
            threshold = DW'($urandom_range(1, 1022));
            for (int unsigned i = 0; i < N; i++) begin
                kind = $urandom_range(0, 5);
                case (kind)
                    0: plan[i].delay = 0;
                    1: plan[i].delay = T;
                    2: plan[i].delay = T + 1;
                    default: plan[i].delay = $urandom_range(1, T - 1);
                endcase
                kind = $urandom_range(0, 2);
                case (kind)
                    0: plan[i].val = threshold;
                    1: plan[i].val = threshold - DW'(1);
                    default: plan[i].val = DW'($urandom);
                endcase
            end
            run_sweep($sformatf("random%0d", k));
        end
    endtask

    task automatic test_back_to_back();
        int unsigned s;
        int unsigned d1;
        int unsigned d2;
        threshold = 10'd100;
        clear_records();
        for (int unsigned i = 0; i < 6; i++) begin
            plan[i].delay = $urandom_range(1, T - 1);
            plan[i].val = DW'($urandom_range(0, 200));
            resp_q.push_back(plan[i]);
        end
        s = cyc;
        start = 1'b1;
        repeat (3) tick();
        start = 1'b1;
        repeat (6) tick();
        start = 1'b1;
        for (int k = 0; k < 800; k++) begin
            tick();
            if (done_cyc.size() >= 2) break;
        end
        repeat (40) tick();
        d1 = model_sweep(s + 1, 0);
        d2 = model_sweep(d1 + 2, 3);
        tests_run++;
        if (done_cyc.size() !== 2 || meas_cyc.size() !== 6) begin
            tests_failed++;
            $display("FAIL b2b_counts: got %0d dones %0d measures, want 2/6", done_cyc.size(), meas_cyc.size());
        end
        if (done_cyc.size() == 2) begin
            tests_run++;
            if (done_cyc[0] !== d1 || done_cyc[1] !== d2) begin
                tests_failed++;
                $display("FAIL b2b_done_cycles: got %0d,%0d, want %0d,%0d", done_cyc[0], done_cyc[1], d1, d2);
            end
        end
        for (int unsigned i = 0; i < 6 && i < meas_cyc.size(); i++) begin
            tests_run++;
            if (meas_cyc[i] !== exp_m[i]) begin
                tests_failed++;
                $display("FAIL b2b_measure_cycle[%0d]: got %0d, want %0d", i, meas_cyc[i], exp_m[i]);
            end
        end
        tests_run++;
        if (dist_flat !== exp_flat() || near !== m_near) begin
            tests_failed++;
            $display("FAIL b2b_results: got %h/%b, want %h/%b", dist_flat, near, exp_flat(), m_near);
        end
    endtask

    task automatic test_abort();
        threshold = 10'd100;
        clear_records();
        plan[0] = '{4, DW'($urandom_range(0, 200))};
        plan[1] = '{0, 10'd0};
        plan[2] = '{3, 10'd1};
        for (int unsigned i = 0; i < N; i++) resp_q.push_back(plan[i]);
        start = 1'b1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (meas_cyc.size() >= 2) break;
        end
        repeat (3) tick();
        start = 1'b1;
        tick();
        en = 1'b0;
        tick();
        m_dist[0] = plan[0].val;
        m_to[0] = 1'b0;
        m_near[0] = (plan[0].val < threshold);
        tests_run++;
        if (busy !== 1'b0 || sel !== 2'd0) begin
            tests_failed++;
            $display("FAIL abort_state: got busy=%b sel=%0d, want 0/0", busy, sel);
        end
        tests_run++;
        if (dist_flat !== exp_flat() || near !== m_near || timed_out !== m_to) begin
            tests_failed++;
            $display("FAIL abort_retained: got %h/%b/%b, want %h/%b/%b",
                     dist_flat, near, timed_out, exp_flat(), m_near, m_to);
        end
        en = 1'b1;
        repeat (60) tick();
        tests_run++;
        if (done_cyc.size() !== 0 || meas_cyc.size() !== 2 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_no_resume: got %0d dones %0d measures busy=%b, want 0/2/0",
                     done_cyc.size(), meas_cyc.size(), busy);
        end
    endtask

    task automatic test_reset_mid_guard();
        threshold = 10'd100;
        clear_records();
        plan[0] = '{3, 10'd77};
        plan[1] = '{5, 10'd150};
        plan[2] = '{5, 10'd150};
        for (int unsigned i = 0; i < N; i++) resp_q.push_back(plan[i]);
        start = 1'b1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (meas_cyc.size() >= 1) break;
        end
        repeat (5) tick();
        tests_run++;
        if (dist_flat[DW-1:0] !== 10'd77 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL guard_pre_reset: got dist0=%0d busy=%b, want 77/1", dist_flat[DW-1:0], busy);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if ({drv_measure, sel, dist_flat, near, timed_out, obstacle, busy, sweep_done} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_guard: got meas=%b sel=%0d dist=%h near=%b to=%b obs=%b busy=%b done=%b, want all 0",
                     drv_measure, sel, dist_flat, near, timed_out, obstacle, busy, sweep_done);
        end
        rst = 1'b1;
        repeat (40) tick();
        tests_run++;
        if (meas_cyc.size() !== 1 || done_cyc.size() !== 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_no_resume: got %0d measures %0d dones busy=%b, want 1/0/0",
                     meas_cyc.size(), done_cyc.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_timeout();
        test_exact_timeout();
        test_random();
        test_back_to_back();
        test_abort();
        test_reset_mid_guard();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
